// File: rtl/serial_to_parallel.sv
// Serial-to-parallel receiver: assembles an LSB-first qualified bit stream into WIDTH-bit words.
// Optional trailing parity bit per frame when SERIAL_TO_PARALLEL_PARITY_EN is defined.
module serial_to_parallel #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_i,
    input  logic             valid_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] parallel_o,
    output logic             valid_o,
    output logic             empty_o,
    output logic             perr_o
);

`ifdef SERIAL_TO_PARALLEL_PARITY_EN
    localparam int unsigned FLEN = WIDTH + 1;
`else
    localparam int unsigned FLEN = WIDTH;
`endif
    localparam int unsigned CW = $clog2(FLEN + 1);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("serial_to_parallel: WIDTH must be in 2..32");
    end
    if (PARITY_ODD > 1) begin : g_bad_parity
        $error("serial_to_parallel: PARITY_ODD must be 0 or 1");
    end

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] assembled;
    logic             last_bit;

    // Word as it would look with the current bit merged in; the parity slot (cnt==WIDTH) matches no index.
    always_comb begin
        assembled = shreg;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (CW'(i) == cnt) begin
                assembled[i] = serial_i;
            end
        end
    end

    assign last_bit = (cnt == CW'(FLEN - 1));
    assign empty_o  = (cnt == '0);

`ifdef SERIAL_TO_PARALLEL_PARITY_EN
    logic parity_err;
    assign parity_err = ((^shreg) ^ serial_i) != PARITY_ODD[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perr_o <= 1'b0;
        end else begin
            perr_o <= valid_i && !clear_i && last_bit && parity_err;
        end
    end
`else
    assign perr_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            shreg      <= '0;
            parallel_o <= '0;
            valid_o    <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (clear_i) begin
                cnt   <= '0;
                shreg <= '0;
            end else if (valid_i) begin
                if (last_bit) begin
                    cnt        <= '0;
                    shreg      <= '0;
                    parallel_o <= assembled;
                    valid_o    <= 1'b1;
                end else begin
                    cnt   <= cnt + CW'(1);
                    shreg <= assembled;
                end
            end
        end
    end

endmodule
